threshold_sequencer: RTL and testbench

//  Top-level controller for the adaptive-thresholding pipeline. On iStart it runs two stages in order:
//  the local-mean filter (fills the threshold memory), then the binarize stage (fills the result memory).

---
 rtl/threshold_sequencer_pkg.sv | 33 +++
 rtl/threshold_sequencer_hold.sv | 30 +++
 rtl/threshold_sequencer.sv | 141 ++++++++++++++
 tb/tb_threshold_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/threshold_sequencer_pkg.sv
// Shared definitions for the thresholding sequencer: FSM states, oStage codes, small helpers.
package threshold_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_F_RST   = 3'd1,
    ST_F_RUN   = 3'd2,
    ST_F_DRAIN = 3'd3,
    ST_B_RST   = 3'd4,
    ST_B_RUN   = 3'd5,
    ST_B_DRAIN = 3'd6,
    ST_DONE    = 3'd7
  } seq_state_t;

  localparam logic [1:0] STAGE_IDLE     = 2'd0;
  localparam logic [1:0] STAGE_FILTER   = 2'd1;
  localparam logic [1:0] STAGE_BINARIZE = 2'd2;
  localparam logic [1:0] STAGE_DONE     = 2'd3;

  function automatic logic [1:0] stage_code(input seq_state_t s);
    case (s)
      ST_IDLE:                         return STAGE_IDLE;
      ST_F_RST, ST_F_RUN, ST_F_DRAIN:  return STAGE_FILTER;
      ST_B_RST, ST_B_RUN, ST_B_DRAIN:  return STAGE_BINARIZE;
      default:                         return STAGE_DONE;
    endcase
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/threshold_sequencer_hold.sv
// Hold counter shared by the stage-reset and drain waits: counts cycles since the last
// state change and flags the limit-th cycle.
module stage_hold_counter #(
  parameter int unsigned CNT_BITS = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic                enable,
  input  logic [CNT_BITS-1:0] limit,
  output logic                done
);

  logic [CNT_BITS-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !done) begin
      count <= count + CNT_BITS'(1);
    end
  end

  always_comb begin
    done = (count == limit - CNT_BITS'(1));
  end

endmodule

// File: rtl/threshold_sequencer.sv
// Two-stage frame sequencer (local-mean filter, then binarize) with image read-address mux.
// Optional per-frame busy-cycle counter on oCycles when THRSEQ_PERF_EN is defined.
module threshold_sequencer
  import threshold_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH_BITS   = 8,
  parameter int unsigned HEIGHT_BITS  = 8,
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned DRAIN_CYCLES = 2
`ifdef THRSEQ_PERF_EN
  ,
  parameter int unsigned CYCLE_BITS   = 20
`endif
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iStart,
  output logic                   oBusy,
  output logic                   oDone,
  output logic [1:0]             oStage,
  output logic                   oFilterReset,
  input  logic                   iFilterFinished,
  output logic                   oBinReset,
  input  logic                   iBinFinished,
  input  logic [WIDTH_BITS-1:0]  iFiltImageCol,
  input  logic [HEIGHT_BITS-1:0] iFiltImageRow,
  input  logic [WIDTH_BITS-1:0]  iBinImageCol,
  input  logic [HEIGHT_BITS-1:0] iBinImageRow,
  input  logic [WIDTH_BITS-1:0]  iHostImageCol,
  input  logic [HEIGHT_BITS-1:0] iHostImageRow,
  output logic [WIDTH_BITS-1:0]  oImageCol,
  output logic [HEIGHT_BITS-1:0] oImageRow
`ifdef THRSEQ_PERF_EN
  ,
  output logic [CYCLE_BITS-1:0]  oCycles
`endif
);

  localparam int unsigned HOLD_BITS = $clog2(max_u(RESET_CYCLES, DRAIN_CYCLES)) + 1;

  seq_state_t           state, state_n;
  logic                 state_change;
  logic                 hold_en, hold_done;
  logic [HOLD_BITS-1:0] hold_limit;

  always_comb begin
    hold_en    = (state == ST_F_RST) || (state == ST_F_DRAIN) ||
                 (state == ST_B_RST) || (state == ST_B_DRAIN);
    hold_limit = ((state == ST_F_RST) || (state == ST_B_RST)) ? HOLD_BITS'(RESET_CYCLES)
                                                              : HOLD_BITS'(DRAIN_CYCLES);
  end

  stage_hold_counter #(
    .CNT_BITS(HOLD_BITS)
  ) u_hold (
    .clock  (clock),
    .reset  (reset),
    .clear  (state_change),
    .enable (hold_en),
    .limit  (hold_limit),
    .done   (hold_done)
  );

  // Finished flags only matter in the matching RUN state; iStart only in IDLE/DONE.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:    if (iStart)          state_n = ST_F_RST;
      ST_F_RST:   if (hold_done)       state_n = ST_F_RUN;
      ST_F_RUN:   if (iFilterFinished) state_n = ST_F_DRAIN;
      ST_F_DRAIN: if (hold_done)       state_n = ST_B_RST;
      ST_B_RST:   if (hold_done)       state_n = ST_B_RUN;
      ST_B_RUN:   if (iBinFinished)    state_n = ST_B_DRAIN;
      ST_B_DRAIN: if (hold_done)       state_n = ST_DONE;
      ST_DONE:    if (iStart)          state_n = ST_F_RST;
      default:                         state_n = ST_IDLE;
    endcase
    state_change = (state_n != state);
  end

  // Outputs are registered by decoding the next state alongside the state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      oBusy        <= 1'b0;
      oDone        <= 1'b0;
      oStage       <= STAGE_IDLE;
      oFilterReset <= 1'b1;
      oBinReset    <= 1'b1;
    end else begin
      state        <= state_n;
      oBusy        <= (state_n != ST_IDLE) && (state_n != ST_DONE);
      oDone        <= (state_n == ST_DONE) && state_change;
      oStage       <= stage_code(state_n);
      oFilterReset <= !((state_n == ST_F_RUN) || (state_n == ST_F_DRAIN));
      oBinReset    <= !((state_n == ST_B_RUN) || (state_n == ST_B_DRAIN));
    end
  end

  always_comb begin
    oImageCol = iHostImageCol;
    oImageRow = iHostImageRow;
    case (state)
      ST_F_RST, ST_F_RUN, ST_F_DRAIN: begin
        oImageCol = iFiltImageCol;
        oImageRow = iFiltImageRow;
      end
      ST_B_RST, ST_B_RUN, ST_B_DRAIN: begin
        oImageCol = iBinImageCol;
        oImageRow = iBinImageRow;
      end
      default: ;
    endcase
  end

`ifdef THRSEQ_PERF_EN
  logic [CYCLE_BITS-1:0] perf_cnt, perf_inc;

  always_comb begin
    perf_inc = (&perf_cnt) ? perf_cnt : perf_cnt + CYCLE_BITS'(1);
  end

  // The DONE-entry edge still closes a busy cycle, so the latched value includes it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_cnt <= '0;
      oCycles  <= '0;
    end else begin
      if ((state_n == ST_F_RST) && state_change) begin
        perf_cnt <= '0;
      end else if (oBusy) begin
        perf_cnt <= perf_inc;
      end
      if ((state_n == ST_DONE) && state_change) begin
        oCycles <= perf_inc;
      end
    end
  end
`endif

endmodule

// File: tb/tb_threshold_sequencer.sv
// Randomized bench for threshold_sequencer: per-frame expected timelines built from stage durations.
module tb_threshold_sequencer;

  localparam int unsigned WB = 2;
  localparam int unsigned HB = 2;
  localparam int unsigned RC = 2;
  localparam int unsigned DC = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          iStart = 1'b0;
  logic          iFilterFinished = 1'b0;
  logic          iBinFinished = 1'b0;
  logic          oBusy, oDone, oFilterReset, oBinReset;
  logic [1:0]    oStage;
  logic [WB-1:0] iFiltImageCol = '0, iBinImageCol = '0, iHostImageCol = '0, oImageCol;
  logic [HB-1:0] iFiltImageRow = '0, iBinImageRow = '0, iHostImageRow = '0, oImageRow;
`ifdef THRSEQ_PERF_EN
  logic [19:0]   oCycles;
  logic [3:0]    sat_cycles;
  logic          sat_busy, sat_done, sat_frst, sat_brst;
  logic [1:0]    sat_stage;
  logic [WB-1:0] sat_col;
  logic [HB-1:0] sat_row;
`endif

  always #5 clock = ~clock;

  threshold_sequencer #(
    .WIDTH_BITS   (WB),
    .HEIGHT_BITS  (HB),
    .RESET_CYCLES (RC),
    .DRAIN_CYCLES (DC)
`ifdef THRSEQ_PERF_EN
    ,
    .CYCLE_BITS   (20)
`endif
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .iStart          (iStart),
    .oBusy           (oBusy),
    .oDone           (oDone),
    .oStage          (oStage),
    .oFilterReset    (oFilterReset),
    .iFilterFinished (iFilterFinished),
    .oBinReset       (oBinReset),
    .iBinFinished    (iBinFinished),
    .iFiltImageCol   (iFiltImageCol),
    .iFiltImageRow   (iFiltImageRow),
    .iBinImageCol    (iBinImageCol),
    .iBinImageRow    (iBinImageRow),
    .iHostImageCol   (iHostImageCol),
    .iHostImageRow   (iHostImageRow),
    .oImageCol       (oImageCol),
    .oImageRow       (oImageRow)
`ifdef THRSEQ_PERF_EN
    ,
    .oCycles         (oCycles)
`endif
  );

`ifdef THRSEQ_PERF_EN
  threshold_sequencer #(
    .WIDTH_BITS   (WB),
    .HEIGHT_BITS  (HB),
    .RESET_CYCLES (RC),
    .DRAIN_CYCLES (DC),
    .CYCLE_BITS   (4)
  ) dut_sat (
    .clock           (clock),
    .reset           (reset),
    .iStart          (iStart),
    .oBusy           (sat_busy),
    .oDone           (sat_done),
    .oStage          (sat_stage),
    .oFilterReset    (sat_frst),
    .iFilterFinished (iFilterFinished),
    .oBinReset       (sat_brst),
    .iBinFinished    (iBinFinished),
    .iFiltImageCol   (iFiltImageCol),
    .iFiltImageRow   (iFiltImageRow),
    .iBinImageCol    (iBinImageCol),
    .iBinImageRow    (iBinImageRow),
    .iHostImageCol   (iHostImageCol),
    .iHostImageRow   (iHostImageRow),
    .oImageCol       (sat_col),
    .oImageRow       (sat_row),
    .oCycles         (sat_cycles)
  );
`endif

  // Expected observation for one clock cycle.
  typedef struct packed {
    logic [1:0] stage;
    logic       frst;
    logic       brst;
    logic       done;
  } exp_t;

  exp_t        sched[$];
  exp_t        cur, rest;
  int unsigned checks = 0, errors = 0;
  int unsigned cur_lf = 16, cur_lb = 16, f_low = 0, b_low = 0;
  int unsigned n_resets = 0, frame_len = 0;
  int unsigned exp_cycles = 0, exp_cycles4 = 0;
  logic [WB-1:0] exp_col;
  logic [HB-1:0] exp_row;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t ent(input logic [1:0] st, input logic fr, input logic br, input logic dn);
    exp_t e;
    e.stage = st;
    e.frst  = fr;
    e.brst  = br;
    e.done  = dn;
    return e;
  endfunction

  // Frame timeline: reset hold, run until finished, drain, for each stage, then DONE entry.
  task automatic push_frame(input int unsigned lf, input int unsigned lb);
    repeat (RC) sched.push_back(ent(2'd1, 1'b1, 1'b1, 1'b0));
    repeat (lf + DC) sched.push_back(ent(2'd1, 1'b0, 1'b1, 1'b0));
    repeat (RC) sched.push_back(ent(2'd2, 1'b1, 1'b1, 1'b0));
    repeat (lb + DC) sched.push_back(ent(2'd2, 1'b1, 1'b0, 1'b0));
    sched.push_back(ent(2'd3, 1'b1, 1'b1, 1'b1));
    cur_lf    = lf;
    cur_lb    = lb;
    frame_len = 2 * RC + 2 * DC + lf + lb;
  endtask

  task automatic check_outputs();
    check_eq("stage", oStage, cur.stage);
    check_eq("busy", oBusy, (cur.stage == 2'd1) || (cur.stage == 2'd2));
    check_eq("done", oDone, cur.done);
    check_eq("filt_rst", oFilterReset, cur.frst);
    check_eq("bin_rst", oBinReset, cur.brst);
  endtask

  initial begin
    rest = ent(2'd0, 1'b1, 1'b1, 1'b0);
    #1 reset = 1'b0;
    #1;
    cur = rest;
    check_outputs();
`ifdef THRSEQ_PERF_EN
    check_eq("cycles_rst", oCycles, 0);
    check_eq("cycles4_rst", sat_cycles, 0);
`endif
    @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b1;

    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clock);
      cur = (sched.size() > 0) ? sched.pop_front() : rest;
      if (cur.stage == 2'd3) rest = ent(2'd3, 1'b1, 1'b1, 1'b0);
      check_outputs();
`ifdef THRSEQ_PERF_EN
      if (cur.done) begin
        exp_cycles  = frame_len;
        exp_cycles4 = (frame_len > 15) ? 15 : frame_len;
      end
      check_eq("cycles", oCycles, exp_cycles);
      check_eq("cycles4", sat_cycles, exp_cycles4);
`endif

      // Asynchronous reset in the middle of the binarize run.
      if (cyc > 400 && n_resets < 3 && cur.stage == 2'd2 && !cur.brst && $urandom_range(9, 0) == 0) begin
        n_resets++;
        reset = 1'b0;
        #1;
        check_eq("rst_stage", oStage, 0);
        check_eq("rst_busy", oBusy, 0);
        check_eq("rst_done", oDone, 0);
        check_eq("rst_filt", oFilterReset, 1);
        check_eq("rst_bin", oBinReset, 1);
        sched.delete();
        rest       = ent(2'd0, 1'b1, 1'b1, 1'b0);
        exp_cycles = 0;
        exp_cycles4 = 0;
        @(posedge clock);
        #2 reset = 1'b1;
        continue;
      end

      f_low = oFilterReset ? 0 : f_low + 1;
      b_low = oBinReset ? 0 : b_low + 1;

      if (cyc < 100)      iStart = (cyc == 3);
      else if (cyc < 400) iStart = 1'b1;
      else                iStart = ($urandom_range(5, 0) == 0);

      if ((cur.stage == 2'd0 || cur.stage == 2'd3) && iStart) begin
        if (cyc < 100) push_frame(16, 16);
        else           push_frame($urandom_range(24, 1), $urandom_range(24, 1));
      end

      iFilterFinished = (!oFilterReset && f_low >= cur_lf) ||
                        (cur.stage != 2'd1 && $urandom_range(3, 0) == 0);
      iBinFinished    = (!oBinReset && b_low >= cur_lb) ||
                        (cur.stage != 2'd2 && $urandom_range(3, 0) == 0);

      iHostImageCol = WB'($urandom);
      iHostImageRow = HB'($urandom);
      iFiltImageCol = iHostImageCol + WB'(1);
      iFiltImageRow = iHostImageRow + HB'(1);
      iBinImageCol  = iHostImageCol + WB'(2);
      iBinImageRow  = iHostImageRow + HB'(2);
      #1;
      case (cur.stage)
        2'd1:    begin exp_col = iFiltImageCol; exp_row = iFiltImageRow; end
        2'd2:    begin exp_col = iBinImageCol;  exp_row = iBinImageRow;  end
        default: begin exp_col = iHostImageCol; exp_row = iHostImageRow; end
      endcase
      check_eq("mux_col", oImageCol, exp_col);
      check_eq("mux_row", oImageRow, exp_row);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
